data_mem_ctr: RTL and testbench
===============================

DATA_MEM_CTR -- requirements
Module: data_mem_ctr

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, number of cycles spent in ACCESS per accepted request (legal range 1..15).
REQ-002 SHALL have parameter ADDR_BITS, default 6, log2 of word count of internal storage (64 x 32-bit words).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port memRead  input  1  read request from the main control decoder.
REQ-006 SHALL have port memWrite  input  1  write request from the main control decoder.
REQ-007 SHALL have port address  input  32  byte address from the ALU; word index = address[ADDR_BITS+1:2], upper bits ignored.
REQ-008 SHALL have port writeData  input  32  store data (rt value).
REQ-009 SHALL have port readData  output  32  load result, registered.
REQ-010 SHALL have port memBusy  output  1  stall to the datapath; PC and pipeline hold while high.
REQ-011 SHALL have port memDone  output  1  one-cycle completion pulse, registered.
REQ-012 SHALL have port memError  output  1  one-cycle pulse on an illegal request, registered.

Function
REQ-013 SHALL implement three states: IDLE, ACCESS, DONE.
REQ-014 A valid request is memRead XOR memWrite, with address[1:0]==2'b00, sampled in IDLE.
REQ-015 On a valid request in IDLE, the edge SHALL latch op, word index and writeData, load the wait counter with WAIT_CYCLES-1, and go to ACCESS.
REQ-016 ACCESS SHALL last exactly WAIT_CYCLES cycles; the counter decrements each cycle, and the edge with counter==0 goes to DONE.
REQ-017 On the ACCESS->DONE edge, a write SHALL commit the latched data to the latched index; a read SHALL load readData from the latched index.
REQ-018 DONE SHALL last one cycle with memDone=1, then return to IDLE unconditionally.
REQ-019 Requests present during ACCESS or DONE SHALL be ignored; a request still held in IDLE is accepted normally.
REQ-020 memBusy SHALL be 1 in ACCESS, 0 in DONE, and in IDLE SHALL equal the combinational valid-request term (Mealy, so the requesting instruction stalls from its first cycle).
REQ-021 Total stall per access = WAIT_CYCLES+1 cycles; memDone is seen in cycle WAIT_CYCLES+1 after the request cycle.
REQ-022 memRead and memWrite both high in IDLE: no access, stay IDLE, memBusy=0, memError=1 in the next cycle.
REQ-023 Misaligned address (address[1:0]!=0) with one request in IDLE: no access, stay IDLE, memBusy=0, memError=1 in the next cycle.
REQ-024 readData SHALL hold its last loaded value until the next completed read; writes and errors leave it unchanged.
REQ-025 Address wrap: indices differing only in bits above ADDR_BITS+1 SHALL alias to the same word.
REQ-026 Write-then-read of the same word in back-to-back accesses SHALL return the new data.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, counter=0, readData=0, memBusy=0 (no request) , memDone=0, memError=0.
REQ-028 Storage contents SHALL NOT be cleared by reset; a write aborted by reset before its ACCESS->DONE edge SHALL NOT commit.
REQ-029 After rst_n rises, the first rising edge with a valid request SHALL be accepted.

Verification
REQ-030 Write 0xDEADBEEF to 0x10, then read 0x10 -> each access stalls 3 cycles (WAIT_CYCLES=2), read gives memDone with readData=0xDEADBEEF.
REQ-031 memRead=memWrite=1, address 0x20 -> memBusy stays 0, memError pulses 1 cycle, readData and word 8 unchanged.
REQ-032 Read at 0x13 -> memError pulse, no memDone, state returns/stays IDLE.
REQ-033 Write 0x12345678 to 0x104, read 0x004 -> readData=0x12345678 (aliasing with ADDR_BITS=6).
REQ-034 Write 0xA5A5A5A5 to 0x40, drop rst_n during first ACCESS cycle, release, read 0x40 -> prior contents returned, not 0xA5A5A5A5; all outputs 0 while in reset.
REQ-035 WAIT_CYCLES=1 and 5 -> memBusy high for exactly 1 and 5 ACCESS cycles plus the request cycle; memDone exactly one cycle each.

Source files
------------

// File: rtl/data_mem_ctr.sv
// Multi-cycle data memory controller: one access at a time, WAIT_CYCLES in ACCESS plus a one-cycle DONE.
// memBusy is Mealy in IDLE so the requesting instruction stalls from its first cycle.
module data_mem_ctr #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_BITS   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        memBusy,
    output logic        memDone,
    output logic        memError
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t               state, stateNext;
    logic [3:0]           waitCnt, waitCntNext;
    logic                 opWrite;
    logic [ADDR_BITS-1:0] idx;
    logic [31:0]          dataLatch;
    logic [31:0]          mem [2**ADDR_BITS];

    logic oneReq, aligned, validReq, badReq, accept, finish;
    logic unusedAddrBits;

    assign oneReq         = memRead ^ memWrite;
    assign aligned        = (address[1:0] == 2'b00);
    assign validReq       = oneReq && aligned;
    assign badReq         = (memRead && memWrite) || (oneReq && !aligned);
    assign unusedAddrBits = ^address[31:ADDR_BITS+2];

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        accept      = 1'b0;
        finish      = 1'b0;
        memBusy     = 1'b0;
        case (state)
            IDLE: begin
                memBusy = validReq;
                if (validReq) begin
                    accept      = 1'b1;
                    stateNext   = ACCESS;
                    waitCntNext = 4'(WAIT_CYCLES - 1);
                end
            end
            ACCESS: begin
                memBusy = 1'b1;
                if (waitCnt == 4'd0) begin
                    finish    = 1'b1;
                    stateNext = DONE;
                end else begin
                    waitCntNext = waitCnt - 4'd1;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        // Keep the stall low while reset is held, even if a request is present.
        if (!rst_n) memBusy = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            waitCnt   <= 4'd0;
            readData  <= 32'd0;
            memDone   <= 1'b0;
            memError  <= 1'b0;
            opWrite   <= 1'b0;
            idx       <= '0;
            dataLatch <= 32'd0;
        end else begin
            state    <= stateNext;
            waitCnt  <= waitCntNext;
            memDone  <= finish;
            memError <= (state == IDLE) && badReq;
            if (accept) begin
                opWrite   <= memWrite;
                idx       <= address[ADDR_BITS+1:2];
                dataLatch <= writeData;
            end
            if (finish && !opWrite) readData <= mem[idx];
        end
    end

    // Storage is never reset; finish is low while reset holds state in IDLE, so an aborted write never commits.
    always_ff @(posedge clk) begin
        if (finish && opWrite) mem[idx] <= dataLatch;
    end
endmodule

// File: tb/tb_data_mem_ctr.sv
// Directed bench for data_mem_ctr: table of accesses on the default instance, plus reset-abort and wait-length sequences.
module tb_data_mem_ctr;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] writeData = 32'd0;
    logic [31:0] readData, readData1, readData5;
    logic        memBusy, memBusy1, memBusy5;
    logic        memDone, memDone1, memDone5;
    logic        memError, memError1, memError5;

    int nVec = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    data_mem_ctr dut (
        .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
        .address(address), .writeData(writeData), .readData(readData),
        .memBusy(memBusy), .memDone(memDone), .memError(memError)
    );

    data_mem_ctr #(.WAIT_CYCLES(1)) dutW1 (
        .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
        .address(address), .writeData(writeData), .readData(readData1),
        .memBusy(memBusy1), .memDone(memDone1), .memError(memError1)
    );

    data_mem_ctr #(.WAIT_CYCLES(5)) dutW5 (
        .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
        .address(address), .writeData(writeData), .readData(readData5),
        .memBusy(memBusy5), .memDone(memDone5), .memError(memError5)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          busy;
        int          done;
        int          err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Request is held like a stalled datapath would: until a cycle with memBusy low, then dropped.
    task automatic runOp(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         output int busy, output int done, output int err, output logic [31:0] rdat);
        logic held;
        busy = 0; done = 0; err = 0; held = 1'b1;
        @(posedge clk); #1;
        memRead = rd; memWrite = wr; address = a; writeData = d;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (memBusy)  busy++;
            if (memDone)  done++;
            if (memError) err++;
            if (held && !memBusy) begin
                @(posedge clk); #1;
                memRead = 1'b0; memWrite = 1'b0; address = 32'd0; writeData = 32'd0;
                held = 1'b0;
            end
        end
        rdat = readData;
    endtask

    initial begin
        int busy, done, err;
        int b1, b2, b5, d1, d2, d5;
        logic [31:0] rdat;

        vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 3, 1, 0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        3, 1, 0, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 1'b1, 32'h20,  32'hCAFEF00D, 3, 1, 0, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b1, 32'h20,  32'h11111111, 0, 0, 1, 32'hDEADBEEF};
        vecs[4]  = '{1'b1, 1'b0, 32'h20,  32'h0,        3, 1, 0, 32'hCAFEF00D};
        vecs[5]  = '{1'b1, 1'b0, 32'h13,  32'h0,        0, 0, 1, 32'hCAFEF00D};
        vecs[6]  = '{1'b0, 1'b1, 32'h12,  32'h77777777, 0, 0, 1, 32'hCAFEF00D};
        vecs[7]  = '{1'b1, 1'b0, 32'h10,  32'h0,        3, 1, 0, 32'hDEADBEEF};
        vecs[8]  = '{1'b0, 1'b1, 32'h104, 32'h12345678, 3, 1, 0, 32'hDEADBEEF};
        vecs[9]  = '{1'b1, 1'b0, 32'h004, 32'h0,        3, 1, 0, 32'h12345678};
        vecs[10] = '{1'b0, 1'b1, 32'h40,  32'h5A5A5A5A, 3, 1, 0, 32'h12345678};
        vecs[11] = '{1'b0, 1'b1, 32'h3C,  32'h0BADF00D, 3, 1, 0, 32'h12345678};
        vecs[12] = '{1'b1, 1'b0, 32'h3C,  32'h0,        3, 1, 0, 32'h0BADF00D};

        // Reset state, with no request present.
        repeat (3) @(negedge clk);
        check("rst memBusy",  {31'd0, memBusy},  32'd0);
        check("rst memDone",  {31'd0, memDone},  32'd0);
        check("rst memError", {31'd0, memError}, 32'd0);
        check("rst readData", readData, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            runOp(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, busy, done, err, rdat);
            check($sformatf("vec%0d busy", i),  busy, vecs[i].busy);
            check($sformatf("vec%0d done", i),  done, vecs[i].done);
            check($sformatf("vec%0d error", i), err,  vecs[i].err);
            check($sformatf("vec%0d readData", i), rdat, vecs[i].rdata);
        end

        // Write aborted by reset during its first ACCESS cycle must not land.
        @(posedge clk); #1;
        memWrite = 1'b1; address = 32'h40; writeData = 32'hA5A5A5A5;
        @(negedge clk);
        check("abort req busy", {31'd0, memBusy}, 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        memWrite = 1'b0; address = 32'd0; writeData = 32'd0;
        #1;
        check("abort rst memBusy",  {31'd0, memBusy},  32'd0);
        check("abort rst memDone",  {31'd0, memDone},  32'd0);
        check("abort rst memError", {31'd0, memError}, 32'd0);
        check("abort rst readData", readData, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        runOp(1'b1, 1'b0, 32'h40, 32'h0, busy, done, err, rdat);
        check("post-abort busy", busy, 3);
        check("post-abort done", done, 1);
        check("post-abort readData", rdat, 32'h5A5A5A5A);

        // Single-cycle request pulse seen by all three wait lengths.
        repeat (10) @(posedge clk);
        #1;
        memRead = 1'b1; address = 32'h10;
        b1 = 0; b2 = 0; b5 = 0; d1 = 0; d2 = 0; d5 = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (memBusy1) b1++;
            if (memBusy)  b2++;
            if (memBusy5) b5++;
            if (memDone1) d1++;
            if (memDone)  d2++;
            if (memDone5) d5++;
            if (c == 0) begin
                @(posedge clk); #1;
                memRead = 1'b0; address = 32'd0;
            end
        end
        check("W1 busy", b1, 2);
        check("W2 busy", b2, 3);
        check("W5 busy", b5, 6);
        check("W1 done", d1, 1);
        check("W2 done", d2, 1);
        check("W5 done", d5, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end
endmodule
